// File: rtl/cmp_result_if.sv
// G/E/L result bus between the comparator side (master) and cmp_result_monitor (slave).
// CMP_MON_IRQ_EN adds the irq/irq_ack pair.
interface cmp_result_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             G;
  logic             E;
  logic             L;
  logic             clr;
  logic             stable_valid;
  logic [1:0]       stable_code;
  logic             stable_change;
  logic [CNT_W-1:0] g_cnt;
  logic [CNT_W-1:0] e_cnt;
  logic [CNT_W-1:0] l_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;
`ifdef CMP_MON_IRQ_EN
  logic             irq_ack;
  logic             irq;

  modport master (
    output in_valid, G, E, L, clr, irq_ack,
    input  stable_valid, stable_code, stable_change,
    input  g_cnt, e_cnt, l_cnt, err_cnt, err_sticky, irq
  );

  modport slave (
    input  in_valid, G, E, L, clr, irq_ack,
    output stable_valid, stable_code, stable_change,
    output g_cnt, e_cnt, l_cnt, err_cnt, err_sticky, irq
  );
`else
  modport master (
    output in_valid, G, E, L, clr,
    input  stable_valid, stable_code, stable_change,
    input  g_cnt, e_cnt, l_cnt, err_cnt, err_sticky
  );

  modport slave (
    input  in_valid, G, E, L, clr,
    output stable_valid, stable_code, stable_change,
    output g_cnt, e_cnt, l_cnt, err_cnt, err_sticky
  );
`endif
endinterface

// File: rtl/cmp_result_monitor.sv
// Counts G/E/L comparator results, flags illegal encodings and tracks a debounced stable code.
// Optional interrupt output enabled with the CMP_MON_IRQ_EN macro.
module cmp_result_monitor #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_result_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TRACK   = 2'd1;
  localparam logic [1:0] ST_STABLE  = 2'd2;
  localparam logic [7:0] STABLE_RUN = 8'(STABLE_CNT);

  logic [1:0] state_reg, state_next;
  logic [7:0] run_reg, run_next;
  logic [1:0] cand_reg, cand_next;
  logic       stable_valid_reg, stable_valid_next;
  logic [1:0] stable_code_reg, stable_code_next;
  logic       stable_change_reg, stable_change_next;
  logic       err_sticky_reg;

  logic [2:0] gel;
  logic       one_hot;
  logic       legal;
  logic       illegal;
  logic [1:0] code;

  assign gel     = {bus.G, bus.E, bus.L};
  assign one_hot = (gel == 3'b100) || (gel == 3'b010) || (gel == 3'b001);
  assign legal   = bus.in_valid && one_hot;
  assign illegal = bus.in_valid && !one_hot;
  assign code    = bus.G ? 2'b11 : (bus.E ? 2'b10 : 2'b01);

  always_comb begin
    state_next         = state_reg;
    run_next           = run_reg;
    cand_next          = cand_reg;
    stable_valid_next  = stable_valid_reg;
    stable_code_next   = stable_code_reg;
    stable_change_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (legal) begin
          state_next = ST_TRACK;
          cand_next  = code;
          run_next   = 8'd1;
        end
      end
      ST_TRACK: begin
        if (legal) begin
          if (code == cand_reg) begin
            run_next = run_reg + 8'd1;
            if (run_reg + 8'd1 == STABLE_RUN) begin
              state_next         = ST_STABLE;
              stable_valid_next  = 1'b1;
              stable_code_next   = cand_reg;
              stable_change_next = !stable_valid_reg || (stable_code_reg != cand_reg);
            end
          end else begin
            cand_next = code;
            run_next  = 8'd1;
          end
        end
      end
      ST_STABLE: begin
        // Published code is kept (hysteresis) while the new candidate builds its run.
        if (legal && (code != cand_reg)) begin
          state_next = ST_TRACK;
          cand_next  = code;
          run_next   = 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        run_next   = 8'd0;
      end
    endcase
    if (illegal) begin
      state_next        = ST_IDLE;
      run_next          = 8'd0;
      stable_valid_next = 1'b0;
      stable_code_next  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      run_reg           <= 8'd0;
      cand_reg          <= 2'b00;
      stable_valid_reg  <= 1'b0;
      stable_code_reg   <= 2'b00;
      stable_change_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      run_reg           <= run_next;
      cand_reg          <= cand_next;
      stable_valid_reg  <= stable_valid_next;
      stable_code_reg   <= stable_code_next;
      stable_change_reg <= stable_change_next;
    end
  end

  // Counter slot order: 0 = L, 1 = E, 2 = G, 3 = illegal.
  logic [3:0]         hit;
  logic [4*CNT_W-1:0] cnt_flat;

  assign hit = {illegal,
                legal && (code == 2'b11),
                legal && (code == 2'b10),
                legal && (code == 2'b01)};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_slot
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (bus.clr) begin
          cnt_reg <= '0;
        end else if (hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_reg <= 1'b0;
    end else if (bus.clr) begin
      err_sticky_reg <= 1'b0;
    end else if (illegal) begin
      err_sticky_reg <= 1'b1;
    end
  end

`ifdef CMP_MON_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else if (stable_change_next || illegal) begin
      irq_reg <= 1'b1;
    end else if (bus.irq_ack) begin
      irq_reg <= 1'b0;
    end
  end

  assign bus.irq = irq_reg;
`endif

  assign bus.stable_valid  = stable_valid_reg;
  assign bus.stable_code   = stable_code_reg;
  assign bus.stable_change = stable_change_reg;
  assign bus.l_cnt         = cnt_flat[0*CNT_W +: CNT_W];
  assign bus.e_cnt         = cnt_flat[1*CNT_W +: CNT_W];
  assign bus.g_cnt         = cnt_flat[2*CNT_W +: CNT_W];
  assign bus.err_cnt       = cnt_flat[3*CNT_W +: CNT_W];
  assign bus.err_sticky    = err_sticky_reg;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Self-checking bench for cmp_result_monitor: directed scenarios plus random traffic
// checked against a run-length reference model. Define CMP_MON_IRQ_EN to cover irq.
module tb_cmp_result_monitor;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = 255;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cmp_result_if #(.CNT_W(CNT_W)) bus ();

  cmp_result_monitor #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: length of the current run of identical legal codes since the last
  // illegal sample or reset; a run reaching exactly STABLE_CNT publishes its code.
  int         m_run_len;
  int         m_run_code;
  logic       m_sv;
  logic [1:0] m_sc;
  logic       m_chg;
  int         m_g, m_e, m_l, m_err;
  logic       m_sticky;
  logic       m_irq;

  task automatic model_reset();
    m_run_len = 0; m_run_code = 0; m_sv = 0; m_sc = 2'b00; m_chg = 0;
    m_g = 0; m_e = 0; m_l = 0; m_err = 0; m_sticky = 0; m_irq = 0;
  endtask

  task automatic model_step(input logic v, g, e, l, c, ack);
    int  code;
    bit  is_legal;
    bit  is_illegal;
    m_chg      = 0;
    is_legal   = v && ((int'(g) + int'(e) + int'(l)) == 1);
    is_illegal = v && !is_legal;
    if (is_legal) begin
      code = g ? 3 : (e ? 2 : 1);
      if (m_run_len > 0 && code == m_run_code) m_run_len++;
      else begin
        m_run_code = code;
        m_run_len  = 1;
      end
      if (m_run_len == STABLE_CNT) begin
        if (!m_sv || m_sc != 2'(code)) m_chg = 1;
        m_sv = 1;
        m_sc = 2'(code);
      end
      if (code == 3 && m_g < CNT_MAX) m_g++;
      if (code == 2 && m_e < CNT_MAX) m_e++;
      if (code == 1 && m_l < CNT_MAX) m_l++;
    end
    if (is_illegal) begin
      m_run_len = 0;
      m_sv      = 0;
      m_sc      = 2'b00;
      if (m_err < CNT_MAX) m_err++;
      m_sticky = 1;
    end
    if (c) begin
      m_g = 0; m_e = 0; m_l = 0; m_err = 0; m_sticky = 0;
    end
    if (m_chg || is_illegal) m_irq = 1;
    else if (ack) m_irq = 0;
  endtask

  task automatic drive(input logic v, g, e, l, c, ack);
    bus.in_valid = v;
    bus.G        = g;
    bus.E        = e;
    bus.L        = l;
    bus.clr      = c;
`ifdef CMP_MON_IRQ_EN
    bus.irq_ack  = ack;
`endif
    @(posedge clk);
    model_step(v, g, e, l, c, ack);
    #1;
    $display("txn t=%0t v=%0b gel=%0b%0b%0b clr=%0b -> sv=%0b sc=%0b chg=%0b g=%0d e=%0d l=%0d err=%0d sticky=%0b",
             $time, v, g, e, l, c, bus.stable_valid, bus.stable_code, bus.stable_change,
             bus.g_cnt, bus.e_cnt, bus.l_cnt, bus.err_cnt, bus.err_sticky);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 0; bus.G = 0; bus.E = 0; bus.L = 0; bus.clr = 0;
`ifdef CMP_MON_IRQ_EN
    bus.irq_ack  = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.stable_valid, bus.stable_code, bus.stable_change, bus.err_sticky} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%0b want=0",
               {bus.stable_valid, bus.stable_code, bus.stable_change, bus.err_sticky});
    end
    checks++;
    if ({bus.g_cnt, bus.e_cnt, bus.l_cnt, bus.err_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnts got=%0h want=0", {bus.g_cnt, bus.e_cnt, bus.l_cnt, bus.err_cnt});
    end
  endtask

  task automatic test_stable_qualify();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.stable_valid !== (i == 4) || bus.stable_change !== (i == 4)) begin
        errors++;
        $display("FAIL qual_sample%0d got sv=%0b chg=%0b want sv=%0b chg=%0b",
                 i, bus.stable_valid, bus.stable_change, i == 4, i == 4);
      end
    end
    checks++;
    if (bus.stable_code !== 2'b11 || bus.g_cnt !== 8'd4) begin
      errors++;
      $display("FAIL qual_code got code=%0b g_cnt=%0d want code=11 g_cnt=4", bus.stable_code, bus.g_cnt);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.stable_change !== 1'b0) begin
      errors++;
      $display("FAIL qual_pulse_width got chg=%0b want 0", bus.stable_change);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 0, 0, 1, 0, 0);
      else       drive(1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.stable_code !== 2'b11 || bus.stable_change !== 1'b0 || bus.stable_valid !== 1'b1) begin
        errors++;
        $display("FAIL hyst_hold%0d got sv=%0b code=%0b chg=%0b want sv=1 code=11 chg=0",
                 i, bus.stable_valid, bus.stable_code, bus.stable_change);
      end
    end
    checks++;
    if (bus.l_cnt !== 8'd3 || bus.g_cnt !== 8'd5) begin
      errors++;
      $display("FAIL hyst_cnts got l=%0d g=%0d want l=3 g=5", bus.l_cnt, bus.g_cnt);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 1, 0, 0);
      checks++;
      if (bus.stable_code !== (i == 4 ? 2'b01 : 2'b11) || bus.stable_change !== (i == 4)) begin
        errors++;
        $display("FAIL hyst_switch%0d got code=%0b chg=%0b want code=%0b chg=%0b",
                 i, bus.stable_code, bus.stable_change, (i == 4 ? 2'b01 : 2'b11), i == 4);
      end
    end
  endtask

  task automatic test_illegal();
    drive(1, 1, 1, 0, 0, 0);
    checks++;
    if (bus.err_cnt !== 8'd1 || bus.err_sticky !== 1'b1 || bus.stable_valid !== 1'b0 ||
        bus.stable_code !== 2'b00) begin
      errors++;
      $display("FAIL illegal_effect got err=%0d sticky=%0b sv=%0b code=%0b want 1 1 0 00",
               bus.err_cnt, bus.err_sticky, bus.stable_valid, bus.stable_code);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 0, 0, 0);
      checks++;
      if (bus.stable_change !== (i == 4) || bus.stable_code !== (i == 4 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL illegal_recover%0d got code=%0b chg=%0b want code=%0b chg=%0b",
                 i, bus.stable_code, bus.stable_change, (i == 4 ? 2'b10 : 2'b00), i == 4);
      end
    end
  endtask

  task automatic test_saturation_clr();
    int chg_seen;
    chg_seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 0, 1, 0, 0);
      if (bus.stable_change === 1'b1) chg_seen++;
    end
    checks++;
    if (bus.l_cnt !== 8'd255 || bus.stable_code !== 2'b01 || chg_seen != 1) begin
      errors++;
      $display("FAIL sat_l got l=%0d code=%0b pulses=%0d want l=255 code=01 pulses=1",
               bus.l_cnt, bus.stable_code, chg_seen);
    end
    drive(1, 0, 0, 1, 1, 0);
    checks++;
    if (bus.l_cnt !== 8'd0 || bus.err_cnt !== 8'd0 || bus.err_sticky !== 1'b0 ||
        bus.stable_code !== 2'b01 || bus.stable_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_sample got l=%0d err=%0d sticky=%0b sv=%0b code=%0b want 0 0 0 1 01",
               bus.l_cnt, bus.err_cnt, bus.err_sticky, bus.stable_valid, bus.stable_code);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if (bus.stable_code !== 2'b01 || bus.stable_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got sv=%0b code=%0b want sv=1 code=01", bus.stable_valid, bus.stable_code);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.stable_valid, bus.stable_code, bus.stable_change, bus.err_sticky,
         bus.g_cnt, bus.e_cnt, bus.l_cnt, bus.err_cnt} !== 37'h0) begin
      errors++;
      $display("FAIL areset_immediate got sv=%0b code=%0b g=%0d l=%0d want all 0",
               bus.stable_valid, bus.stable_code, bus.g_cnt, bus.l_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.stable_valid !== (i == 4) || bus.stable_change !== (i == 4)) begin
        errors++;
        $display("FAIL areset_requal%0d got sv=%0b chg=%0b want %0b", i, bus.stable_valid,
                 bus.stable_change, i == 4);
      end
    end
  endtask

`ifdef CMP_MON_IRQ_EN
  task automatic test_irq();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_on_illegal got=%0b want=1", bus.irq);
    end
    for (int i = 1; i <= 4; i++) drive(1, 1, 0, 0, 0, i == 4);
    checks++;
    if (bus.irq !== 1'b1 || bus.stable_change !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins got irq=%0b chg=%0b want 1 1", bus.irq, bus.stable_change);
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack_clear got=%0b want=0", bus.irq);
    end
  endtask
`endif

  task automatic test_random();
    int         cur;
    logic       v, c, ack;
    logic [2:0] x;
    do_reset();
    cur = 1;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 4) == 0) cur = $urandom_range(1, 3);
      x = (cur == 3) ? 3'b100 : ((cur == 2) ? 3'b010 : 3'b001);
      if ($urandom_range(0, 19) == 0) begin
        x = 3'($urandom_range(0, 7));
        if (x == 3'b001 || x == 3'b010 || x == 3'b100) x = 3'b111;
      end
      if (!v) x = 3'($urandom_range(0, 7));
      c   = ($urandom_range(0, 39) == 0);
      ack = ($urandom_range(0, 3) == 0);
      drive(v, x[2], x[1], x[0], c, ack);
      checks++;
      if (bus.stable_valid !== m_sv || bus.stable_code !== m_sc || bus.stable_change !== m_chg ||
          bus.g_cnt !== 8'(m_g) || bus.e_cnt !== 8'(m_e) || bus.l_cnt !== 8'(m_l) ||
          bus.err_cnt !== 8'(m_err) || bus.err_sticky !== m_sticky) begin
        errors++;
        $display("FAIL rand%0d got sv=%0b sc=%0b chg=%0b g=%0d e=%0d l=%0d err=%0d st=%0b want %0b %0b %0b %0d %0d %0d %0d %0b",
                 i, bus.stable_valid, bus.stable_code, bus.stable_change, bus.g_cnt, bus.e_cnt,
                 bus.l_cnt, bus.err_cnt, bus.err_sticky, m_sv, m_sc, m_chg, m_g, m_e, m_l,
                 m_err, m_sticky);
      end
`ifdef CMP_MON_IRQ_EN
      checks++;
      if (bus.irq !== m_irq) begin
        errors++;
        $display("FAIL rand_irq%0d got=%0b want=%0b", i, bus.irq, m_irq);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_reset();
    test_reset();
    test_stable_qualify();
    test_hysteresis();
    test_illegal();
    test_saturation_clr();
    test_async_reset();
`ifdef CMP_MON_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
